mf_unit_pipe: RTL and testbench

Parametrised, pipelined successor to the single-bit multifunction gate. It applies a mode-selected function bitwise to two WIDTH-bit operands. The low-mode encoding stays bit-compatible with the original gate: x, y, y, ~x. It adds AND/OR/XOR modes and an accumulating XOR mode backed by an internal register. The block sits between a valid/ready producer and consumer, sustains one transaction per cycle, and has a fixed 2-cycle latency when not stalled.

---
 rtl/mf_unit_pipe.sv | 82 ++++++++
 tb/tb_mf_unit_pipe.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mf_unit_pipe.sv
// mf_unit_pipe: two-stage valid/ready pipeline applying a mode-selected bitwise function to x/y
//   ports: clk, rst (sync, active-high); in_valid/in_ready with x, y, mode, acc_clr;
//          out_valid/out_ready with out_f and out_zero (out_f == 0)
module mf_unit_pipe #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   input  logic [2:0]       mode,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_f,
   output logic             out_zero
);
   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_x_q, s1_x_d, s1_y_q, s1_y_d;
   logic [2:0]       s1_mode_q, s1_mode_d;
   logic             s1_clr_q, s1_clr_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_f_q, out_f_d;
   logic             out_zero_q, out_zero_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             xfer, accept;
   logic [WIDTH-1:0] base, res;
   always_comb begin
      xfer     = s1_valid_q && (!out_valid_q || out_ready);
      in_ready = !rst && (!s1_valid_q || xfer);
      accept   = in_valid && in_ready;
      // a clear applies to the accumulator whatever the mode of its transaction
      base     = s1_clr_q ? '0 : acc_q;
      case (s1_mode_q)
         3'b000:  res = s1_x_q;
         3'b001:  res = s1_y_q;
         3'b010:  res = s1_y_q;
         3'b011:  res = ~s1_x_q;
         3'b100:  res = s1_x_q & s1_y_q;
         3'b101:  res = s1_x_q | s1_y_q;
         3'b110:  res = s1_x_q ^ s1_y_q;
         default: res = base ^ s1_x_q;
      endcase
      s1_valid_d  = accept ? 1'b1 : (xfer ? 1'b0 : s1_valid_q);
      s1_x_d      = accept ? x : s1_x_q;
      s1_y_d      = accept ? y : s1_y_q;
      s1_mode_d   = accept ? mode : s1_mode_q;
      s1_clr_d    = accept ? acc_clr : s1_clr_q;
      out_valid_d = xfer ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
      out_f_d     = xfer ? res : out_f_q;
      out_zero_d  = xfer ? ~|res : out_zero_q;
      acc_d       = xfer ? ((s1_mode_q == 3'b111) ? res : base) : acc_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_x_q      <= '0;
         s1_y_q      <= '0;
         s1_mode_q   <= '0;
         s1_clr_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_f_q     <= '0;
         out_zero_q  <= 1'b0;
         acc_q       <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_x_q      <= s1_x_d;
         s1_y_q      <= s1_y_d;
         s1_mode_q   <= s1_mode_d;
         s1_clr_q    <= s1_clr_d;
         out_valid_q <= out_valid_d;
         out_f_q     <= out_f_d;
         out_zero_q  <= out_zero_d;
         acc_q       <= acc_d;
      end
   end
   assign out_valid = out_valid_q;
   assign out_f     = out_f_q;
   assign out_zero  = out_zero_q;
endmodule

// File: tb/tb_mf_unit_pipe.sv
// tb_mf_unit_pipe: directed and streaming checks of mf_unit_pipe at WIDTH 8, 1 and 32
module tb_mf_unit_pipe;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   logic       in_valid = 0, in_ready, acc_clr = 0, out_valid, out_ready = 1, out_zero;
   logic [7:0] x = 0, y = 0, out_f;
   logic [2:0] mode = 0;
   mf_unit_pipe #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
      .mode(mode), .acc_clr(acc_clr), .out_valid(out_valid), .out_ready(out_ready),
      .out_f(out_f), .out_zero(out_zero));
   logic        s_valid = 0, s_clr = 0;
   logic [31:0] s_x = 0, s_y = 0;
   logic [2:0]  s_mode = 0;
   logic        u1_in_ready, u1_out_valid, u1_out_zero, u32_in_ready, u32_out_valid, u32_out_zero;
   logic [0:0]  u1_out_f;
   logic [31:0] u32_out_f;
   mf_unit_pipe #(.WIDTH(1)) u1 (
      .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(u1_in_ready), .x(s_x[0:0]), .y(s_y[0:0]),
      .mode(s_mode), .acc_clr(s_clr), .out_valid(u1_out_valid), .out_ready(1'b1),
      .out_f(u1_out_f), .out_zero(u1_out_zero));
   mf_unit_pipe #(.WIDTH(32)) u32 (
      .clk(clk), .rst(rst), .in_valid(s_valid), .in_ready(u32_in_ready), .x(s_x), .y(s_y),
      .mode(s_mode), .acc_clr(s_clr), .out_valid(u32_out_valid), .out_ready(1'b1),
      .out_f(u32_out_f), .out_zero(u32_out_zero));
   int n_chk = 0, n_fail = 0;
   logic hs;
   typedef struct {
      logic [2:0] mode;
      logic [7:0] x, y;
      logic       clr;
      logic [7:0] f;
      logic       z;
   } vec_t;
   vec_t tv[14];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   // hs records whether a handshake is presented in the cycle just ending
   task automatic cyc();
      #1;
      hs = in_valid && in_ready;
      @(posedge clk);
      #1;
   endtask
   task automatic one(input string nm, input logic [2:0] m, input logic [7:0] a, input logic [7:0] b,
                      input logic c, input logic [7:0] f, input logic z);
      in_valid = 1; mode = m; x = a; y = b; acc_clr = c;
      cyc();
      chk({nm, "_hs"}, 32'(hs), 1);
      in_valid = 0;
      chk({nm, "_lat"}, 32'(out_valid), 0);
      cyc();
      chk({nm, "_valid"}, 32'(out_valid), 1);
      chk({nm, "_f"}, 32'(out_f), 32'(f));
      chk({nm, "_zero"}, 32'(out_zero), 32'(z));
   endtask
   function automatic logic [31:0] fn(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] base);
      case (m)
         3'd0: fn = a;
         3'd1, 3'd2: fn = b;
         3'd3: fn = ~a;
         3'd4: fn = a & b;
         3'd5: fn = a | b;
         3'd6: fn = a ^ b;
         default: fn = base ^ a;
      endcase
   endfunction
   logic [7:0]  acc_x[3], acc_e[3];
   logic [31:0] q1[$], q32[$];
   logic [31:0] acc1, acc32, b1, b32, e;
   int ii, io;
   initial begin
      tv[0]  = '{3'b000, 8'hA5, 8'h3C, 1'b0, 8'hA5, 1'b0};
      tv[1]  = '{3'b001, 8'hA5, 8'h3C, 1'b0, 8'h3C, 1'b0};
      tv[2]  = '{3'b010, 8'hA5, 8'h3C, 1'b0, 8'h3C, 1'b0};
      tv[3]  = '{3'b011, 8'hA5, 8'h3C, 1'b0, 8'h5A, 1'b0};
      tv[4]  = '{3'b100, 8'hA5, 8'h3C, 1'b0, 8'h24, 1'b0};
      tv[5]  = '{3'b101, 8'hA5, 8'h3C, 1'b0, 8'hBD, 1'b0};
      tv[6]  = '{3'b110, 8'hA5, 8'h3C, 1'b0, 8'h99, 1'b0};
      tv[7]  = '{3'b100, 8'h0F, 8'hF0, 1'b0, 8'h00, 1'b1};
      tv[8]  = '{3'b111, 8'h01, 8'h00, 1'b0, 8'h01, 1'b0};
      tv[9]  = '{3'b111, 8'h02, 8'h00, 1'b0, 8'h03, 1'b0};
      tv[10] = '{3'b111, 8'h04, 8'h00, 1'b0, 8'h07, 1'b0};
      tv[11] = '{3'b111, 8'h10, 8'h00, 1'b1, 8'h10, 1'b0};
      tv[12] = '{3'b000, 8'h33, 8'h00, 1'b1, 8'h33, 1'b0};
      tv[13] = '{3'b111, 8'h08, 8'h00, 1'b0, 8'h08, 1'b0};
      acc_x = '{8'h01, 8'h02, 8'h04};
      acc_e = '{8'h01, 8'h03, 8'h07};
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_f", 32'(out_f), 0);
      chk("rst_out_zero", 32'(out_zero), 0);
      chk("rst_in_ready", 32'(in_ready), 0);
      rst = 0;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 1);
      foreach (tv[i]) one($sformatf("vec%0d", i), tv[i].mode, tv[i].x, tv[i].y, tv[i].clr, tv[i].f, tv[i].z);
      cyc();
      // backpressure: two accepts fill S1+S2, then a 5-cycle stall
      mode = 0; acc_clr = 0; out_ready = 0; in_valid = 1; x = 8'h11;
      cyc();
      chk("bp_acc1", 32'(hs), 1);
      x = 8'h22;
      cyc();
      chk("bp_acc2", 32'(hs), 1);
      chk("bp_valid", 32'(out_valid), 1);
      x = 8'h33;
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk("bp_stall_hs", 32'(hs), 0);
         chk("bp_stall_f", 32'(out_f), 8'h11);
         chk("bp_stall_valid", 32'(out_valid), 1);
      end
      out_ready = 1;
      #1;
      chk("bp_release_ready", 32'(in_ready), 1);
      cyc();
      chk("bp_release_hs", 32'(hs), 1);
      chk("bp_drain2", 32'(out_f), 8'h22);
      in_valid = 0;
      cyc();
      chk("bp_drain3_valid", 32'(out_valid), 1);
      chk("bp_drain3", 32'(out_f), 8'h33);
      cyc();
      chk("bp_empty", 32'(out_valid), 0);
      // accumulator sequence under random out_ready
      ii = 0; io = 0; mode = 3'b111; y = 0;
      for (int c = 0; c < 200 && io < 3; c++) begin
         in_valid = ii < 3;
         x = acc_x[ii < 3 ? ii : 0];
         acc_clr = ii == 0;
         out_ready = 1'($urandom_range(0, 1));
         #1;
         if (out_valid && out_ready) begin
            chk("rnd_acc_f", 32'(out_f), 32'(acc_e[io]));
            io++;
         end
         if (in_valid && in_ready) ii++;
         @(posedge clk);
         #1;
      end
      chk("rnd_acc_count", io, 3);
      in_valid = 0; out_ready = 1; acc_clr = 0;
      cyc();
      // reset with both stages full and acc = 0x55
      one("acc55", 3'b111, 8'h55, 8'h00, 1'b1, 8'h55, 1'b0);
      cyc();
      out_ready = 0; in_valid = 1; mode = 0; x = 8'hAA;
      cyc();
      x = 8'hBB;
      cyc();
      chk("full_valid", 32'(out_valid), 1);
      chk("full_ready", 32'(in_ready), 0);
      rst = 1; in_valid = 0;
      #1;
      chk("mid_rst_in_ready", 32'(in_ready), 0);
      cyc();
      chk("mid_rst_valid", 32'(out_valid), 0);
      chk("mid_rst_f", 32'(out_f), 0);
      chk("mid_rst_zero", 32'(out_zero), 0);
      chk("mid_rst_in_ready2", 32'(in_ready), 0);
      rst = 0; out_ready = 1;
      one("after_rst_acc", 3'b111, 8'h01, 8'h00, 1'b0, 8'h01, 1'b0);
      cyc();
      // full-rate streaming at WIDTH 1 and 32
      rst = 1;
      cyc();
      rst = 0;
      acc1 = 0; acc32 = 0;
      for (int c = 0; c < 102; c++) begin
         s_valid = c < 100;
         s_x = $urandom; s_y = $urandom; s_mode = 3'($urandom_range(0, 7)); s_clr = $urandom_range(0, 7) == 0;
         #1;
         if (s_valid && u1_in_ready) begin
            b1 = s_clr ? 0 : acc1;
            e = fn(s_mode, s_x & 1, s_y & 1, b1) & 1;
            q1.push_back(e);
            acc1 = (s_mode == 3'b111) ? e : b1;
         end
         if (s_valid && u32_in_ready) begin
            b32 = s_clr ? 0 : acc32;
            e = fn(s_mode, s_x, s_y, b32);
            q32.push_back(e);
            acc32 = (s_mode == 3'b111) ? e : b32;
         end
         if (c >= 2) begin
            chk("w1_valid", 32'(u1_out_valid), 1);
            chk("w32_valid", 32'(u32_out_valid), 1);
            if (u1_out_valid && q1.size() > 0) begin
               e = q1.pop_front();
               chk("w1_f", 32'(u1_out_f), e);
               chk("w1_zero", 32'(u1_out_zero), 32'(e == 0));
            end
            if (u32_out_valid && q32.size() > 0) begin
               e = q32.pop_front();
               chk("w32_f", u32_out_f, e);
               chk("w32_zero", 32'(u32_out_zero), 32'(e == 0));
            end
         end
         @(posedge clk);
         #1;
      end
      chk("w1_left", q1.size(), 0);
      chk("w32_left", q32.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
